// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - statetype : 4-bit main FSM state encoding
//   - OP_*      : opcode field values (instr[31:26])
//   - FN_*      : R-type funct field values (instr[5:0])
//   - aluop_t   : FSM-to-ALU-decoder operation class
//   - ALU_*     : alucontrol encodings driven to the datapath ALU
//   - ctrl_t    : bundle of per-state Moore control signals
//   - state_ctrl: maps a state to its Moore control bundle
// ---------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } statetype;

   // Opcodes
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // Operation class handed from the FSM to the ALU decoder
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_RSVD  = 2'b11
   } aluop_t;

   // ALU operation encodings
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU B operand select
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   // Next-PC select
   localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
   localparam logic [1:0] PCSRC_JUMP      = 2'b10;

   // Moore control bundle; everything not set by a state stays 0
   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      aluop_t     aluop;
   } ctrl_t;

   // Control values asserted while the FSM sits in state s.
   // Illegal encodings get the all-zero bundle; they never reach the
   // output register because the next-state logic maps them to FETCH.
   function automatic ctrl_t state_ctrl(input statetype s);
      ctrl_t c;
      c       = '0;
      c.aluop = ALUOP_ADD;
      case (s)
         FETCH: begin
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = SRCB_FOUR;
         end
         DECODE: begin
            // Branch target precomputed into ALUOut while decoding
            c.alusrcb = SRCB_IMMSH2;
         end
         MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
         end
         MEMRD: begin
            c.iord = 1'b1;
         end
         MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         RTYPEEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_REG;
            c.aluop   = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         BEQEX: begin
            c.alusrca = 1'b1;
            c.branch  = 1'b1;
            c.pcsrc   = PCSRC_ALUOUT;
            c.aluop   = ALUOP_SUB;
         end
         ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
         end
         ADDIWB: begin
            c.regwrite = 1'b1;
         end
         JEX: begin
            c.pcwrite = 1'b1;
            c.pcsrc   = PCSRC_JUMP;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ---------------------------------------------------------------------------
// aludec
// Combinational ALU decoder. Turns the FSM's operation class and the
// instruction funct field into the 3-bit ALU operation.
//   aluop      in  2  operation class from the FSM
//   funct      in  6  instr[5:0], only meaningful for ALUOP_FUNCT
//   alucontrol out 3  ALU operation to the datapath
// ---------------------------------------------------------------------------
module aludec
   import mips_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      // NOTE: assigning a default before the case means every path drives
      // alucontrol, so no latch is inferred for unlisted aluop/funct values.
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Control unit of the multicycle MIPS. A Moore FSM walks each instruction
// through fetch / decode / execute / memory / writeback and drives every
// datapath select and strobe; an ALU decoder maps the FSM's aluop and the
// funct field onto the ALU operation.
//   clk        in   1  system clock, rising edge
//   reset      in   1  async active-high, forces FETCH
//   op         in   6  instr[31:26] from the IR
//   funct      in   6  instr[5:0] from the IR
//   zero       in   1  ALU zero flag (used only in BEQEX)
//   pcen       out  1  PC enable = pcwrite | (branch & zero)
//   iord       out  1  memory address: 0 = PC, 1 = ALUOut
//   memwrite   out  1  memory write strobe
//   irwrite    out  1  instruction register load
//   regdst     out  1  write register: 0 = rt, 1 = rd
//   memtoreg   out  1  write data: 0 = ALUOut, 1 = Data
//   regwrite   out  1  register file write enable
//   alusrca    out  1  ALU A: 0 = PC, 1 = A
//   alusrcb    out  2  ALU B: B / 4 / SignImm / SignImm<<2
//   pcsrc      out  2  next PC: ALUResult / ALUOut / jump target
//   alucontrol out  3  ALU operation
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol
);

   statetype state_q, state_d;
   ctrl_t    ctrl_q,  ctrl_d;

   // Next-state logic. op is read only in DECODE and MEMADR.
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW,
               OP_SW:    state_d = MEMADR;
               OP_RTYPE: state_d = RTYPEEX;
               OP_BEQ:   state_d = BEQEX;
               OP_ADDI:  state_d = ADDIEX;
               OP_J:     state_d = JEX;
               default:  state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_d = MEMWB;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         // MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX and illegal codes
         default: state_d = FETCH;
      endcase
   end

   // Outputs are registered alongside the state: the bundle for the state
   // being entered is computed here and captured on the same edge, so the
   // output flops always hold the Moore values of state_q.
   always_comb begin
      ctrl_d = state_ctrl(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         // NOTE: the output register is reset to the FETCH bundle rather
         // than zero, so the datapath sees fetch controls during reset and
         // any write strobe in flight drops the instant reset asserts.
         state_q <= FETCH;
         ctrl_q  <= state_ctrl(FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Branch resolves in BEQEX from the live zero flag
   assign pcen     = ctrl_q.pcwrite | (ctrl_q.branch & zero);
   assign iord     = ctrl_q.iord;
   assign memwrite = ctrl_q.memwrite;
   assign irwrite  = ctrl_q.irwrite;
   assign regdst   = ctrl_q.regdst;
   assign memtoreg = ctrl_q.memtoreg;
   assign regwrite = ctrl_q.regwrite;
   assign alusrca  = ctrl_q.alusrca;
   assign alusrcb  = ctrl_q.alusrcb;
   assign pcsrc    = ctrl_q.pcsrc;

   aludec u_aludec (
      .aluop      (ctrl_q.aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Self-checking bench: reset checks, a table of per-instruction key-cycle
// expectations, hand sequences (sw pulse, reset abort of sw), then random
// instruction streams compared cycle by cycle against a model that knows
// each instruction as a list of cycles and what every cycle drives.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_multicycle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol)
   );

   typedef struct packed {
      logic       pcen;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alucontrol;
   } out_t;

   out_t got;
   assign got = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                 alusrca, alusrcb, pcsrc, alucontrol};

   function automatic out_t mk(input logic pe, io, mw, irw, rd, m2r, rw, asa,
                               input logic [1:0] asb, pcs,
                               input logic [2:0] alu);
      return {pe, io, mw, irw, rd, m2r, rw, asa, asb, pcs, alu};
   endfunction

   function automatic out_t fetch_o();
      return mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
   endfunction

   // Instruction lengths in cycles
   function automatic int instr_len(input logic [5:0] o);
      case (o)
         6'b100011: return 5;
         6'b101011: return 4;
         6'b000000: return 4;
         6'b001000: return 4;
         6'b000100: return 3;
         6'b000010: return 3;
         default:   return 2;
      endcase
   endfunction

   function automatic logic [2:0] r_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected outputs in cycle k (0-based) of an instruction
   function automatic out_t model(input logic [5:0] o, input logic [5:0] f,
                                  input logic z, input int k);
      out_t addr_calc;
      addr_calc = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010);
      if (k == 0) return fetch_o();
      if (k == 1) return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
      case (o)
         6'b100011: begin
            if (k == 2) return addr_calc;
            if (k == 3) return mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
            return mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010);
         end
         6'b101011: begin
            if (k == 2) return addr_calc;
            return mk(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
         end
         6'b001000: begin
            if (k == 2) return addr_calc;
            return mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010);
         end
         6'b000000: begin
            if (k == 2) return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, r_alu(f));
            return mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010);
         end
         6'b000100: return mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110);
         6'b000010: return mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010);
         default:   return fetch_o();
      endcase
   endfunction

   task automatic check(input string name, input out_t g, input out_t e);
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", name, g, e);
      end
   endtask

   task automatic check_int(input string name, input int g, input int e);
      checks++;
      if (g != e) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d", name, g, e);
      end
   endtask

   // Run one instruction. zmode: 0/1 = fixed zero, 2 = random per cycle.
   // key_k >= 0 adds a table comparison in that cycle; abort_k >= 0 asserts
   // reset in that cycle and abandons the instruction.
   task automatic run_instr(input string name, input logic [5:0] iop,
                            input logic [5:0] ifn, input int zmode,
                            input int key_k, input out_t key_e,
                            input int abort_k);
      int len;
      int mw_cnt;
      int rw_cnt;
      len    = instr_len(iop);
      mw_cnt = 0;
      rw_cnt = 0;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         op    = (k == 0) ? 6'($urandom) : iop;
         funct = (k == 2) ? ifn : 6'($urandom);
         zero  = (zmode == 2) ? 1'($urandom) : zmode[0];
         if (k == abort_k) begin
            reset = 1'b1;
            #1;
            check({name, " abort now"}, got, fetch_o());
            @(posedge clk);
            #1;
            check({name, " abort held"}, got, fetch_o());
            #1 reset = 1'b0;
            return;
         end
         #1;
         check($sformatf("%s k=%0d", name, k), got, model(iop, funct, zero, k));
         if (k == key_k) check({name, " key"}, got, key_e);
         mw_cnt += int'(memwrite);
         rw_cnt += int'(regwrite);
      end
      check_int({name, " memwrite pulses"}, mw_cnt, (iop == 6'b101011) ? 1 : 0);
      check_int({name, " regwrite pulses"}, rw_cnt,
                (iop == 6'b100011 || iop == 6'b000000 || iop == 6'b001000) ? 1 : 0);
   endtask

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] funct;
      int         zmode;
      int         key_k;
      out_t       key_e;
   } vec_t;

   vec_t vecs[18];

   initial begin
      vecs[0]  = '{"lw memrd",   6'b100011, 6'b000000, 2, 3, mk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010)};
      vecs[1]  = '{"lw memwb",   6'b100011, 6'b000000, 2, 4, mk(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010)};
      vecs[2]  = '{"lw memadr",  6'b100011, 6'b000000, 2, 2, mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010)};
      vecs[3]  = '{"r add",      6'b000000, 6'b100000, 2, 2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010)};
      vecs[4]  = '{"r sub",      6'b000000, 6'b100010, 2, 2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b110)};
      vecs[5]  = '{"r and",      6'b000000, 6'b100100, 2, 2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000)};
      vecs[6]  = '{"r or",       6'b000000, 6'b100101, 2, 2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b001)};
      vecs[7]  = '{"r slt",      6'b000000, 6'b101010, 2, 2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111)};
      vecs[8]  = '{"r other",    6'b000000, 6'b000111, 2, 2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010)};
      vecs[9]  = '{"r wb",       6'b000000, 6'b100010, 2, 3, mk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010)};
      vecs[10] = '{"beq taken",  6'b000100, 6'b000000, 1, 2, mk(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110)};
      vecs[11] = '{"beq not",    6'b000100, 6'b000000, 0, 2, mk(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110)};
      vecs[12] = '{"sw memwr",   6'b101011, 6'b000000, 2, 3, mk(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b010)};
      vecs[13] = '{"addi ex",    6'b001000, 6'b000000, 2, 2, mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010)};
      vecs[14] = '{"addi wb",    6'b001000, 6'b000000, 2, 3, mk(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010)};
      vecs[15] = '{"j",          6'b000010, 6'b000000, 2, 2, mk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010)};
      vecs[16] = '{"illegal",    6'b111111, 6'b000000, 2, 1, mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010)};
      vecs[17] = '{"beq rand z", 6'b000100, 6'b000000, 2, -1, mk(0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000)};

      // Reset held three cycles with garbage on the inputs
      reset = 1'b1;
      op    = 6'b100011;
      funct = 6'b101010;
      zero  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         op   = 6'($urandom);
         zero = 1'($urandom);
         #1;
         check($sformatf("reset cycle %0d", i), got, fetch_o());
      end
      // Release mid-cycle; FETCH->DECODE happens on the following edge
      @(posedge clk);
      #2 reset = 1'b0;

      for (int i = 0; i < 18; i++)
         run_instr(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zmode,
                   vecs[i].key_k, vecs[i].key_e, -1);

      // sw completes normally, then a second sw is aborted in MEMADR
      run_instr("sw full", 6'b101011, 6'b0, 2, -1, fetch_o(), -1);
      run_instr("sw abort", 6'b101011, 6'b0, 2, -1, fetch_o(), 2);
      run_instr("after abort", 6'b100011, 6'b0, 2, -1, fetch_o(), -1);

      // Random instruction stream
      for (int n = 0; n < 300; n++) begin
         logic [5:0] rop, rfn;
         case ($urandom_range(0, 6))
            0: rop = 6'b100011;
            1: rop = 6'b101011;
            2: rop = 6'b000000;
            3: rop = 6'b000100;
            4: rop = 6'b001000;
            5: rop = 6'b000010;
            default: rop = 6'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: rfn = 6'b100000;
            1: rfn = 6'b100010;
            2: rfn = 6'b100100;
            3: rfn = 6'b100101;
            4: rfn = 6'b101010;
            default: rfn = 6'($urandom);
         endcase
         run_instr($sformatf("rand%0d op=%b fn=%b", n, rop, rfn), rop, rfn, 2,
                   -1, fetch_o(), -1);
      end

      // The last instruction must hand back to FETCH
      @(negedge clk);
      #1;
      check("final fetch", got, fetch_o());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
